snake_item_gen: RTL and testbench

Item placement generator for the snake game. On request from the game FSM's item-creation step, it draws pseudo-random board coordinates from a seedable 16-bit LFSR and rejects any candidate outside the playfield. It then queries the game's occupancy logic over a valid/response handshake and rejects any cell held by the snake. It returns the accepted item position with a one-cycle done pulse, or a fail flag if the retry budget runs out.

---
 rtl/snake_item_gen_if.sv | 31 +++
 rtl/snake_item_gen.sv | 123 ++++++++++++
 tb/tb_snake_item_gen.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_item_gen_if.sv
// Request, occupancy-query and result signals between the game logic and
// the item placement generator.
interface snake_item_gen_if;
  logic        i_Start;
  logic        i_Seed_Load;
  logic [15:0] i_Seed;
  logic        i_Occ_Valid;
  logic        i_Occupied;
  logic        o_Query_Valid;
  logic [5:0]  o_Query_x;
  logic [5:0]  o_Query_y;
  logic [5:0]  o_Item_x;
  logic [5:0]  o_Item_y;
  logic        o_Done;
  logic        o_Busy;
  logic        o_Fail;

  // Game side: issues requests, answers occupancy queries.
  modport master (
    output i_Start, i_Seed_Load, i_Seed, i_Occ_Valid, i_Occupied,
    input  o_Query_Valid, o_Query_x, o_Query_y, o_Item_x, o_Item_y,
           o_Done, o_Busy, o_Fail
  );

  // Generator side.
  modport slave (
    input  i_Start, i_Seed_Load, i_Seed, i_Occ_Valid, i_Occupied,
    output o_Query_Valid, o_Query_x, o_Query_y, o_Item_x, o_Item_y,
           o_Done, o_Busy, o_Fail
  );
endinterface

// File: rtl/snake_item_gen.sv
// Snake item placement generator: draws candidates from a 16-bit Fibonacci
// LFSR, rejects cells outside the playfield or occupied by the snake, and
// reports the accepted cell (or a failure once the retry budget is spent).
module snake_item_gen #(
  parameter int XSIZE   = 48,   // max valid x, range 1..XSIZE
  parameter int YSIZE   = 63,   // max valid y, range 1..YSIZE (<= 63)
  parameter int MAX_TRY = 255   // rejections allowed before failing (1..255)
) (
  input  logic              i_Clk,
  input  logic              i_Rst,   // asynchronous, active-low
  snake_item_gen_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, GEN, QUERY, DONE} state_t;

  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
  localparam logic [5:0]  X_MAX        = 6'(XSIZE);
  localparam logic [5:0]  Y_MAX        = 6'(YSIZE);
  localparam logic [7:0]  TRY_LIMIT    = 8'(MAX_TRY);

  state_t      state;
  logic [15:0] lfsr;
  logic [7:0]  try_cnt;

  logic [15:0] lfsr_next;
  logic [5:0]  cand_x;
  logic [5:0]  cand_y;
  logic        in_range;
  logic [7:0]  try_inc;
  logic        last_try;

  // Taps x^16+x^14+x^13+x^11+1, shifting the feedback in at the bottom.
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign cand_x    = lfsr_next[5:0];
  assign cand_y    = lfsr_next[11:6];
  // Coordinate 0 is the NULL cell, so it is never a legal placement.
  assign in_range  = (cand_x != 6'd0) && (cand_x <= X_MAX) &&
                     (cand_y != 6'd0) && (cand_y <= Y_MAX);
  assign try_inc   = try_cnt + 8'd1;
  assign last_try  = (try_inc == TRY_LIMIT);

  // Request FSM with LFSR, retry counter and all registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      // NOTE: the LFSR resets to a non-zero seed; an all-zero LFSR would lock up.
      state             <= IDLE;
      lfsr              <= SEED_DEFAULT;
      try_cnt           <= 8'd0;
      bus.o_Query_Valid <= 1'b0;
      bus.o_Query_x     <= 6'd0;
      bus.o_Query_y     <= 6'd0;
      bus.o_Item_x      <= 6'd0;
      bus.o_Item_y      <= 6'd0;
      bus.o_Done        <= 1'b0;
      bus.o_Busy        <= 1'b0;
      bus.o_Fail        <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here, so every branch reads the
      // pre-edge values of state, lfsr and try_cnt regardless of order.
      bus.o_Done <= 1'b0;
      case (state)
        IDLE: begin
          // A seed loaded alongside i_Start is what GEN advances from next.
          if (bus.i_Seed_Load)
            lfsr <= (bus.i_Seed == 16'd0) ? SEED_DEFAULT : bus.i_Seed;
          if (bus.i_Start) begin
            try_cnt    <= 8'd0;
            bus.o_Fail <= 1'b0;
            bus.o_Busy <= 1'b1;
            state      <= GEN;
          end
        end

        GEN: begin
          lfsr          <= lfsr_next;
          bus.o_Query_x <= cand_x;
          bus.o_Query_y <= cand_y;
          if (in_range) begin
            bus.o_Query_Valid <= 1'b1;
            state             <= QUERY;
          end else begin
            try_cnt <= try_inc;
            if (last_try) begin
              bus.o_Fail <= 1'b1;
              bus.o_Done <= 1'b1;
              state      <= DONE;
            end
          end
        end

        QUERY: begin
          // Query stays up with a stable candidate until the game answers.
          if (bus.i_Occ_Valid) begin
            bus.o_Query_Valid <= 1'b0;
            if (!bus.i_Occupied) begin
              bus.o_Item_x <= bus.o_Query_x;
              bus.o_Item_y <= bus.o_Query_y;
              bus.o_Done   <= 1'b1;
              state        <= DONE;
            end else begin
              try_cnt <= try_inc;
              if (last_try) begin
                bus.o_Fail <= 1'b1;
                bus.o_Done <= 1'b1;
                state      <= DONE;
              end else begin
                state <= GEN;
              end
            end
          end
        end

        DONE: begin
          bus.o_Busy <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_item_gen.sv
// Scoreboard bench for snake_item_gen: directed requests push the expected
// result (cell, fail flag, done cycle); monitors pop on every o_Done.
module tb_snake_item_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  snake_item_gen_if bus0 ();
  snake_item_gen_if bus1 ();

  snake_item_gen dut0 (.i_Clk(clk), .i_Rst(rst), .bus(bus0));
  snake_item_gen #(.MAX_TRY(4)) dut1 (.i_Clk(clk), .i_Rst(rst), .bus(bus1));

  typedef struct {
    logic [5:0] x;
    logic [5:0] y;
    logic       fail;
    int         cyc;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Responder controls per DUT.
  int resp_wait[2];
  int occ_ones[2];
  int wait_left[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Responder for dut0: optional wait, then answers; first occ_ones answers are Occupied.
  always @(negedge clk) begin
    if (bus0.i_Occ_Valid && bus0.i_Occupied && occ_ones[0] > 0) occ_ones[0]--;
    if (bus0.o_Query_Valid) begin
      if (wait_left[0] > 0) begin
        bus0.i_Occ_Valid = 1'b0;
        wait_left[0]--;
      end else begin
        bus0.i_Occ_Valid = 1'b1;
        bus0.i_Occupied  = (occ_ones[0] > 0);
      end
    end else begin
      bus0.i_Occ_Valid = 1'b0;
      bus0.i_Occupied  = 1'b0;
      wait_left[0]     = resp_wait[0];
    end
  end

  // Responder for dut1.
  always @(negedge clk) begin
    if (bus1.i_Occ_Valid && bus1.i_Occupied && occ_ones[1] > 0) occ_ones[1]--;
    if (bus1.o_Query_Valid) begin
      if (wait_left[1] > 0) begin
        bus1.i_Occ_Valid = 1'b0;
        wait_left[1]--;
      end else begin
        bus1.i_Occ_Valid = 1'b1;
        bus1.i_Occupied  = (occ_ones[1] > 0);
      end
    end else begin
      bus1.i_Occ_Valid = 1'b0;
      bus1.i_Occupied  = 1'b0;
      wait_left[1]     = resp_wait[1];
    end
  end

  // Monitors: every o_Done must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && bus0.o_Done) begin
      if (sb0.size() == 0) begin
        n_checks++;
        $display("FAIL dut0_unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb0.pop_front();
        check("dut0_item_x", bus0.o_Item_x, e.x);
        check("dut0_item_y", bus0.o_Item_y, e.y);
        check("dut0_fail",   bus0.o_Fail,   e.fail);
        check("dut0_done_cycle", cyc, e.cyc);
      end
    end
    if (rst && bus1.o_Done) begin
      if (sb1.size() == 0) begin
        n_checks++;
        $display("FAIL dut1_unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb1.pop_front();
        check("dut1_item_x", bus1.o_Item_x, e.x);
        check("dut1_item_y", bus1.o_Item_y, e.y);
        check("dut1_fail",   bus1.o_Fail,   e.fail);
        check("dut1_done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus0.i_Start = 1'b0; bus0.i_Seed_Load = 1'b0; bus0.i_Seed = 16'd0;
    bus1.i_Start = 1'b0; bus1.i_Seed_Load = 1'b0; bus1.i_Seed = 16'd0;
    resp_wait[0] = 0; resp_wait[1] = 0;
    occ_ones[0]  = 0; occ_ones[1]  = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Issue one request; lat is the edge (after edge 0) on which o_Done rises.
  // Returns at the negedge after edge 0.
  task automatic start_req(input int d, input logic [5:0] x, input logic [5:0] y,
                           input logic fail, input int lat, input bit push,
                           input bit seed_ld, input logic [15:0] seed);
    exp_t e;
    @(negedge clk);
    e.x = x; e.y = y; e.fail = fail; e.cyc = cyc + 1 + lat;
    if (d == 0) begin
      bus0.i_Start = 1'b1; bus0.i_Seed_Load = seed_ld; bus0.i_Seed = seed;
      if (push) sb0.push_back(e);
    end else begin
      bus1.i_Start = 1'b1; bus1.i_Seed_Load = seed_ld; bus1.i_Seed = seed;
      if (push) sb1.push_back(e);
    end
    @(negedge clk);
    bus0.i_Start = 1'b0; bus0.i_Seed_Load = 1'b0;
    bus1.i_Start = 1'b0; bus1.i_Seed_Load = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (((d == 0) ? bus0.o_Busy : bus1.o_Busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      $display("FAIL dut%0d_busy_timeout: still busy after %0d cycles, expected idle", d, n);
    end
  endtask

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.i_Occ_Valid = 1'b0; bus0.i_Occupied = 1'b0;
    bus1.i_Occ_Valid = 1'b0; bus1.i_Occupied = 1'b0;
    wait_left[0] = 0; wait_left[1] = 0;
    do_reset();

    // Reset values.
    check("rst_item_x",      bus0.o_Item_x,      6'd0);
    check("rst_item_y",      bus0.o_Item_y,      6'd0);
    check("rst_query_x",     bus0.o_Query_x,     6'd0);
    check("rst_query_y",     bus0.o_Query_y,     6'd0);
    check("rst_query_valid", bus0.o_Query_Valid, 1'b0);
    check("rst_done",        bus0.o_Done,        1'b0);
    check("rst_busy",        bus0.o_Busy,        1'b0);
    check("rst_fail",        bus0.o_Fail,        1'b0);

    // Immediate free answer: LFSR 0x59C3 -> (3,39), done edge 2, busy falls edge 3.
    start_req(0, 6'd3, 6'd39, 1'b0, 2, 1'b1, 1'b0, 16'd0);
    check("t1_busy_e0", bus0.o_Busy, 1'b1);
    @(negedge clk);
    check("t1_qvalid_e1", bus0.o_Query_Valid, 1'b1);
    @(negedge clk);
    check("t1_busy_e2", bus0.o_Busy, 1'b1);
    @(negedge clk);
    check("t1_busy_e3", bus0.o_Busy, 1'b0);
    check("t1_done_e3", bus0.o_Done, 1'b0);

    // One occupied answer: second candidate 0xB387 -> (7,14), done edge 4.
    do_reset();
    occ_ones[0] = 1;
    start_req(0, 6'd7, 6'd14, 1'b0, 4, 1'b1, 1'b0, 16'd0);
    wait_idle(0);

    // Seed 0x0001 loaded with start: ten out-of-range, then (1,32), done edge 12.
    do_reset();
    start_req(0, 6'd1, 6'd32, 1'b0, 12, 1'b1, 1'b1, 16'h0001);
    wait_idle(0);
    // Seed 0 is replaced by 0xACE1 -> (3,39).
    start_req(0, 6'd3, 6'd39, 1'b0, 2, 1'b1, 1'b1, 16'h0000);
    wait_idle(0);

    // MAX_TRY=4, always occupied: fail on edge 8, item stays NULL.
    do_reset();
    occ_ones[1] = 1000;
    start_req(1, 6'd0, 6'd0, 1'b1, 8, 1'b1, 1'b0, 16'd0);
    wait_idle(1);
    repeat (2) @(negedge clk);
    check("t4_fail_held", bus1.o_Fail, 1'b1);
    // Next request from LFSR 0xCE1E: three out-of-range, then (36,7) on edge 5.
    occ_ones[1] = 0;
    start_req(1, 6'd36, 6'd7, 1'b0, 5, 1'b1, 1'b0, 16'd0);
    check("t4_fail_cleared", bus1.o_Fail, 1'b0);
    wait_idle(1);

    // Delayed answer; start and seed load pulsed during QUERY are ignored.
    do_reset();
    resp_wait[0] = 3;
    start_req(0, 6'd3, 6'd39, 1'b0, 5, 1'b1, 1'b0, 16'd0);
    @(negedge clk);
    bus0.i_Start = 1'b1; bus0.i_Seed_Load = 1'b1; bus0.i_Seed = 16'h0001;
    for (int i = 1; i <= 4; i++) begin
      check("t5_qvalid_held", bus0.o_Query_Valid, 1'b1);
      check("t5_qx_held",     bus0.o_Query_x,     6'd3);
      check("t5_qy_held",     bus0.o_Query_y,     6'd39);
      if (i < 4) @(negedge clk);
      bus0.i_Start = 1'b0; bus0.i_Seed_Load = 1'b0;
    end
    wait_idle(0);
    // LFSR untouched by the ignored seed load: continues to (7,14).
    resp_wait[0] = 0;
    start_req(0, 6'd7, 6'd14, 1'b0, 2, 1'b1, 1'b0, 16'd0);
    wait_idle(0);

    // Reset during QUERY aborts with no done; next request restarts at (3,39).
    do_reset();
    start_req(0, 6'd3, 6'd39, 1'b0, 2, 1'b1, 1'b0, 16'd0);
    wait_idle(0);
    resp_wait[0] = 3;
    start_req(0, 6'd0, 6'd0, 1'b0, 0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    check("t6_in_query", bus0.o_Query_Valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("t6_async_qvalid", bus0.o_Query_Valid, 1'b0);
    check("t6_async_busy",   bus0.o_Busy,        1'b0);
    check("t6_async_qx",     bus0.o_Query_x,     6'd0);
    check("t6_async_item_x", bus0.o_Item_x,      6'd0);
    check("t6_async_item_y", bus0.o_Item_y,      6'd0);
    @(negedge clk);
    rst = 1'b1;
    resp_wait[0] = 0;
    repeat (4) @(negedge clk);
    start_req(0, 6'd3, 6'd39, 1'b0, 2, 1'b1, 1'b0, 16'd0);
    wait_idle(0);
    repeat (3) @(negedge clk);

    check("sb0_drained", sb0.size(), 0);
    check("sb1_drained", sb1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
